// File: rtl/slave_port.sv
// Slave endpoint of the bit-serial system bus: deserialises address/burst/write
// data into local memory and serialises read data back over the response path.
module slave_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic master_valid,
  input  logic master_ready,
  input  logic read_en,
  input  logic write_en,
  input  logic tx_address,
  input  logic tx_burst,
  input  logic tx_data,
  input  logic tx_done,
  output logic slave_ready,
  output logic slave_valid,
  output logic rx_data,
  output logic rx_done
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] BURST_BITS = CW'(BURST_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RLOAD, S_RDATA, S_DONE
  } state_t;

  state_t                 state_q;
  logic                   is_read_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [BURST_WIDTH-1:0] word_cnt_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wshift_q;
  logic [DATA_WIDTH-1:0]  rshift_q;

  logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];

  logic [DATA_WIDTH-1:0]  wword_d;
  logic [BURST_WIDTH-1:0] burst_d;
  logic                   abort_d;
  logic                   mem_we_d;

  assign wword_d  = {tx_data, wshift_q[DATA_WIDTH-1:1]};
  assign burst_d  = BURST_WIDTH'({tx_burst, burst_q} >> 1);
  assign abort_d  = tx_done && (state_q != S_IDLE) && (state_q != S_DONE);
  // Abort wins over the final data bit, so a partial word never reaches memory.
  assign mem_we_d = (state_q == S_WDATA) && master_valid && !tx_done &&
                    (bit_cnt_q == DATA_LAST);

  always_ff @(posedge clk) begin
    if (mem_we_d) mem[addr_q] <= wword_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_read_q  <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
      wshift_q   <= '0;
      rshift_q   <= '0;
    end else if (abort_d) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (master_valid && (read_en ^ write_en)) begin
            is_read_q  <= read_en;
            addr_q     <= {tx_address, addr_q[ADDR_WIDTH-1:1]};
            burst_q    <= burst_d;
            bit_cnt_q  <= CW'(1);
            word_cnt_q <= '0;
            state_q    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (master_valid) begin
            addr_q <= {tx_address, addr_q[ADDR_WIDTH-1:1]};
            if (bit_cnt_q < BURST_BITS) burst_q <= burst_d;
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= is_read_q ? S_RLOAD : S_WDATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        S_WDATA: begin
          if (master_valid) begin
            wshift_q <= wword_d;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q  <= '0;
              addr_q     <= addr_q + ADDR_WIDTH'(1);
              word_cnt_q <= word_cnt_q + BURST_WIDTH'(1);
              if (word_cnt_q == burst_q) state_q <= S_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        S_RLOAD: begin
          rshift_q <= mem[addr_q];
          state_q  <= S_RDATA;
        end
        S_RDATA: begin
          if (master_ready) begin
            rshift_q <= {1'b0, rshift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q  <= '0;
              addr_q     <= addr_q + ADDR_WIDTH'(1);
              word_cnt_q <= word_cnt_q + BURST_WIDTH'(1);
              state_q    <= (word_cnt_q == burst_q) ? S_DONE : S_RLOAD;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign slave_valid = (state_q == S_RDATA);
  assign rx_data     = (state_q == S_RDATA) && rshift_q[0];
  assign rx_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_slave_port.sv
// Self-checking bench for slave_port: directed vector table, hand-written
// abort/reset/illegal-start sequences, and random traffic against a memory model.
`timescale 1ns/1ps
module tb_slave_port;

  logic clk = 1'b0;
  logic rst, master_valid, master_ready, read_en, write_en;
  logic tx_address, tx_burst, tx_data, tx_done;
  logic slave_ready, slave_valid, rx_data, rx_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [4096];
  bit         model_known [4096];

  slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .BURST_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .master_valid(master_valid), .master_ready(master_ready),
    .read_en(read_en), .write_en(write_en),
    .tx_address(tx_address), .tx_burst(tx_burst), .tx_data(tx_data), .tx_done(tx_done),
    .slave_ready(slave_ready), .slave_valid(slave_valid),
    .rx_data(rx_data), .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    master_valid = 0; master_ready = 0; read_en = 0; write_en = 0;
    tx_address = 0; tx_burst = 0; tx_data = 0; tx_done = 0;
  endtask

  // Drives the 12 address bits; returns at the negedge after the last address edge.
  task automatic send_addr(input bit rd, input logic [11:0] a, input logic [1:0] b, input bit gaps);
    for (int i = 0; i < 12; i++) begin
      if (gaps && i == 6) begin
        for (int g = 0; g < 3; g++) begin
          master_valid = 0;
          tx_address = 1'($urandom); tx_burst = 1'($urandom);
          read_en = 1'($urandom); write_en = 1'($urandom);
          @(negedge clk);
          chk("addr_gap_ready", 32'(slave_ready), 32'd1);
        end
      end
      master_valid = 1; read_en = rd; write_en = !rd;
      tx_address = a[i];
      if (i < 2) tx_burst = b[i[0]];
      else       tx_burst = 1'($urandom);
      @(negedge clk);
      if (i < 11) chk("addr_ready", 32'(slave_ready), 32'd1);
    end
    master_valid = 0;
  endtask

  task automatic write_txn(input logic [11:0] a, input logic [1:0] b, input logic [31:0] d,
                           input bit gaps, input int abort_word);
    $display("write addr=%03h burst=%0d data=%08h gaps=%0d abort_word=%0d", a, b, d, gaps, abort_word);
    send_addr(0, a, b, gaps);
    chk("wdata_entry_ready", 32'(slave_ready), 32'd1);
    for (int w = 0; w <= int'(b); w++) begin
      for (int i = 0; i < 8; i++) begin
        if (w == abort_word && i == 4) begin
          tx_done = 1; master_valid = 1; tx_data = 1'($urandom);
          @(negedge clk);
          idle_inputs();
          chk("abort_ready", 32'(slave_ready), 32'd1);
          chk("abort_no_done", 32'(rx_done), 32'd0);
          @(negedge clk);
          chk("abort_no_done2", 32'(rx_done), 32'd0);
          for (int k = 0; k < abort_word; k++) begin
            model_mem[12'(a + 12'(k))] = d[8*k +: 8];
            model_known[12'(a + 12'(k))] = 1;
          end
          return;
        end
        if (gaps && w == 0 && i == 4) begin
          for (int g = 0; g < 3; g++) begin
            master_valid = 0; tx_data = 1'($urandom);
            @(negedge clk);
            chk("data_gap_ready", 32'(slave_ready), 32'd1);
          end
        end
        master_valid = 1; tx_data = d[8*w + i];
        @(negedge clk);
        if (!(w == int'(b) && i == 7)) begin
          chk("wdata_ready", 32'(slave_ready), 32'd1);
          chk("wdata_no_done", 32'(rx_done), 32'd0);
        end
      end
    end
    idle_inputs();
    for (int k = 0; k <= int'(b); k++) begin
      model_mem[12'(a + 12'(k))] = d[8*k +: 8];
      model_known[12'(a + 12'(k))] = 1;
    end
    chk("wr_done_pulse", 32'(rx_done), 32'd1);
    chk("wr_done_not_ready", 32'(slave_ready), 32'd0);
    @(negedge clk);
    chk("wr_done_single", 32'(rx_done), 32'd0);
    chk("wr_idle_ready", 32'(slave_ready), 32'd1);
  endtask

  // rmode: 0 = always ready, 1 = toggle 1,0,1,0 per word, 2 = random.
  task automatic read_txn(input logic [11:0] a, input logic [1:0] b, input logic [31:0] exp,
                          input bit gaps, input int rmode);
    $display("read  addr=%03h burst=%0d expect=%08h gaps=%0d rmode=%0d", a, b, exp, gaps, rmode);
    send_addr(1, a, b, gaps);
    for (int w = 0; w <= int'(b); w++) begin
      int acc = 0;
      int cyc = 0;
      chk("rload_valid", 32'(slave_valid), 32'd0);
      chk("rload_ready", 32'(slave_ready), 32'd0);
      chk("rload_no_done", 32'(rx_done), 32'd0);
      master_ready = 1'($urandom);
      @(negedge clk);
      while (acc < 8) begin
        bit r;
        chk("rdata_valid", 32'(slave_valid), 32'd1);
        chk("rdata_bit", 32'(rx_data), 32'(exp[8*w + acc]));
        if (rmode == 0)      r = 1;
        else if (rmode == 1) r = (cyc % 2 == 0);
        else                 r = 1'($urandom_range(0, 1));
        master_ready = r;
        cyc++;
        @(negedge clk);
        if (r) acc++;
        if (cyc > 200) begin
          chk("rdata_cycle_budget", 32'(cyc), 32'd200);
          break;
        end
      end
    end
    idle_inputs();
    chk("rd_done_pulse", 32'(rx_done), 32'd1);
    chk("rd_done_valid", 32'(slave_valid), 32'd0);
    @(negedge clk);
    chk("rd_done_single", 32'(rx_done), 32'd0);
    chk("rd_idle_ready", 32'(slave_ready), 32'd1);
  endtask

  typedef struct {
    bit          rd;
    logic [11:0] a;
    logic [1:0]  b;
    logic [31:0] d;
    bit          gaps;
    int          rmode;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 12'h05A, 2'd0, 32'h000000C3, 0, 0};
    vecs[1] = '{1, 12'h05A, 2'd0, 32'h000000C3, 0, 0};
    vecs[2] = '{0, 12'hFFE, 2'd3, 32'h44332211, 0, 0};
    vecs[3] = '{1, 12'hFFE, 2'd3, 32'h44332211, 0, 0};
    vecs[4] = '{0, 12'h801, 2'd0, 32'h000000A5, 1, 0};
    vecs[5] = '{1, 12'h801, 2'd0, 32'h000000A5, 0, 1};
    vecs[6] = '{1, 12'hFFF, 2'd1, 32'h00003322, 0, 1};

    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(slave_ready), 32'd1);
    chk("reset_valid", 32'(slave_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_done", 32'(rx_done), 32'd0);
    rst = 0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rd) read_txn(vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].gaps, vecs[v].rmode);
      else            write_txn(vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].gaps, -1);
    end

    // Abort during the third word of a burst: only the first two words land.
    write_txn(12'h102, 2'd0, 32'h000000EE, 0, -1);
    write_txn(12'h100, 2'd3, 32'h8D7C6B5A, 0, 2);
    read_txn(12'h100, 2'd2, 32'h00EE6B5A, 0, 0);

    // Both enables, then neither: no transaction may start.
    $display("illegal start: read_en=write_en=1 then 0/0 with master_valid=1");
    for (int i = 0; i < 16; i++) begin
      master_valid = 1; read_en = (i < 12); write_en = (i < 12);
      tx_address = 1'($urandom); tx_burst = 1'($urandom); tx_data = 1'($urandom);
      tx_done = 1'($urandom);
      @(negedge clk);
      chk("illegal_ready", 32'(slave_ready), 32'd1);
      chk("illegal_valid", 32'(slave_valid), 32'd0);
      chk("illegal_done", 32'(rx_done), 32'd0);
    end
    idle_inputs();
    @(negedge clk);
    read_txn(12'h05A, 2'd0, 32'h000000C3, 0, 0);

    // Asynchronous reset in the middle of a read.
    $display("reset mid-read at addr 05a");
    send_addr(1, 12'h05A, 2'd0, 0);
    master_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_bit1", 32'(rx_data), 32'd1);
    chk("pre_reset_valid", 32'(slave_valid), 32'd1);
    rst = 1;
    #1;
    chk("async_reset_valid", 32'(slave_valid), 32'd0);
    chk("async_reset_rx_data", 32'(rx_data), 32'd0);
    chk("async_reset_ready", 32'(slave_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(negedge clk);
    read_txn(12'h05A, 2'd0, 32'h000000C3, 0, 0);

    // Random traffic checked against the memory model.
    for (int t = 0; t < 16; t++) begin
      logic [11:0] wa, ra;
      logic [1:0]  wb, rb;
      logic [31:0] wd, exp;
      wa = 12'($urandom);
      wb = 2'($urandom);
      wd = $urandom;
      write_txn(wa, wb, wd, 1'($urandom), -1);
      ra = 12'(wa + 12'($urandom_range(0, int'(wb))));
      rb = 2'($urandom);
      while (rb > 0 && !model_known[12'(ra + 12'(rb))]) rb--;
      exp = '0;
      for (int k = 0; k <= int'(rb); k++) exp[8*k +: 8] = model_mem[12'(ra + 12'(k))];
      read_txn(ra, rb, exp, 1'($urandom), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Slave-side endpoint of the bit-serial system bus, one instance per slave, fed by the master-to-slave routing mux.
- Deserialises address, burst length and write data from the granted master.
- Stores write data in local memory; serialises read data back toward the master over the response path.
- Ends each transaction with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 12, serial address bits per transaction; local memory depth 2^ADDR_WIDTH.
- DATA_WIDTH, 8, bits per data word.
- BURST_WIDTH, 2, serial burst-code bits; words per transaction = code+1, giving 1..4.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- master_valid  in  1  master presents a valid address/data bit this cycle.
- master_ready  in  1  master accepts a read-data bit this cycle.
- read_en  in  1  transaction is a read; sampled at start.
- write_en  in  1  transaction is a write; sampled at start.
- tx_address  in  1  serial address, LSB first.
- tx_burst  in  1  serial burst code, LSB first, parallel with the first BURST_WIDTH address bits.
- tx_data  in  1  serial write data, LSB first.
- tx_done  in  1  master abort/terminate.
- slave_ready  out  1  slave accepting address/write bits.
- slave_valid  out  1  rx_data carries a valid read bit.
- rx_data  out  1  serial read data, LSB first.
- rx_done  out  1  one-cycle transaction-complete pulse.

Behaviour:
- Reset, asynchronous:
  - State=IDLE; counters, address and shift registers = 0.
  - slave_ready=1, slave_valid=0, rx_data=0, rx_done=0.
  - Memory contents are not reset.
- Outputs are Moore decodes of registered state/shift registers:
  - slave_ready=1 in IDLE, ADDR and WDATA; 0 otherwise.
  - slave_valid=1 only in RDATA.
  - rx_done=1 only in DONE.
- IDLE:
  - Start when master_valid=1 and exactly one of read_en/write_en=1; latch the direction.
  - The address/burst bit of the start cycle is bit 0.
  - Both enables high, or neither high: ignored, stay IDLE.
- ADDR:
  - Each master_valid=1 cycle shifts one tx_address bit; the first BURST_WIDTH such bits also shift tx_burst.
  - master_valid=0 stalls with no shift.
  - After bit ADDR_WIDTH-1: go to WDATA (write) or RLOAD (read).
- WDATA:
  - Each master_valid=1 cycle shifts one tx_data bit.
  - After DATA_WIDTH bits: mem[addr]<=word in the same clock edge, addr<=addr+1 mod 2^ADDR_WIDTH, word count+1.
  - After burst+1 words: DONE.
- RLOAD:
  - One cycle; rdata shift register <= mem[addr]; slave_valid=0.
  - Next state RDATA.
- RDATA:
  - rx_data=shift[0].
  - A bit transfers on a cycle with master_ready=1; the register then shifts right.
  - master_ready=0 holds rx_data stable.
  - After DATA_WIDTH transfers: addr+1 with wrap; RLOAD if words remain, else DONE.
- DONE: rx_done=1 for exactly one cycle, then IDLE.
- tx_done=1 in any state other than IDLE/DONE:
  - Abort to IDLE on the next edge, with no rx_done.
  - Completed write words remain in memory; a partial word is discarded.
- tx_done in IDLE is ignored. tx_done has priority over the bit shift in the same cycle.
- read_en/write_en changes after start are ignored.
- Write-to-memory and read-from-memory never occur in the same cycle.

Test Plan:
- Single write, burst 0, addr 0x05A, data 0xC3, master_valid held high → rx_done pulses the cycle after the 8th data bit. Follow with a read of 0x05A, master_ready=1 → rx_data sequence 1,1,0,0,0,0,1,1, slave_valid high 8 cycles, then rx_done.
- Burst-3 write at 0xFFE of 0x11,0x22,0x33,0x44 → read-back returns 0x11@0xFFE, 0x22@0xFFF, 0x33@0x000, 0x44@0x001 (address wrap).
- master_valid low for 3 cycles mid-address (addr 0x801) and mid-data (0xA5) → no shift during gaps; mem[0x801]=0xA5. Read with master_ready toggled 1,0,1,0 → each bit held until accepted; slave_valid drops for the one RLOAD cycle between burst words.
- Burst-3 write from 0x100; tx_done asserted during the 3rd word → only 0x100 and 0x101 are updated, 0x102 is unchanged, state IDLE next cycle, no rx_done pulse.
- read_en=write_en=1 with master_valid=1 → stays IDLE, slave_ready=1, memory unchanged.
- rst asserted mid-RDATA → immediately slave_valid=0, rx_data=0, slave_ready=1. After release, a new single read returns the correct prior memory data.
